axis_dwidth_downsizer_pipe: RTL

//  AXI4-Stream width downsizer, successor to the single-word shift downsizer.

---
 rtl/axis_dwidth_downsizer_pipe_if.sv | 19 +
 rtl/axis_dwidth_downsizer_pipe.sv | 137 +++++++++++++
 2 files changed

// File: rtl/axis_dwidth_downsizer_pipe_if.sv
// AXI4-Stream bundle used on both sides of the width downsizer.
// DATA_W sets the tdata width. tkeep (DATA_W/8 bits) exists only when
// AXIS_DOWN_TKEEP_EN is defined.
// Modports: master drives tvalid/tdata/tlast(/tkeep) and samples tready;
// slave is the mirror image.
interface axis_dwidth_downsizer_pipe_if #(parameter int DATA_W = 32) ();
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
`ifdef AXIS_DOWN_TKEEP_EN
  logic [DATA_W/8-1:0] tkeep;
  modport master (output tvalid, tdata, tlast, tkeep, input tready);
  modport slave  (input tvalid, tdata, tlast, tkeep, output tready);
`else
  modport master (output tvalid, tdata, tlast, input tready);
  modport slave  (input tvalid, tdata, tlast, output tready);
`endif
endinterface

// File: rtl/axis_dwidth_downsizer_pipe.sv
// AXI4-Stream width downsizer. Each RATIO*OUT_WIDTH input word is held in
// one register and emitted as RATIO OUT_WIDTH slices, MSB slice first when
// MSB_FIRST=1, otherwise LSB slice first. The next word is accepted during
// the handshake of the final slice, which gives a sustained rate of one
// slice per cycle with no idle cycles between words.
// Optional feature macro: AXIS_DOWN_TKEEP_EN. When it is defined, tkeep is
// carried, all-zero-keep slices are skipped, and tlast moves to the last
// non-null slice. An all-zero word is dropped, unless it carries tlast; in
// that case it produces a single null beat.
// Ports:
//   aclk, aresetn  clock and asynchronous active-low reset
//   s_axis         slave side, RATIO*OUT_WIDTH data
//   m_axis         master side, OUT_WIDTH data
module axis_dwidth_downsizer_pipe #(
  parameter int OUT_WIDTH = 32,
  parameter int RATIO     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic aclk,
  input  logic aresetn,
  axis_dwidth_downsizer_pipe_if.slave  s_axis,
  axis_dwidth_downsizer_pipe_if.master m_axis
);
  localparam int IN_W = RATIO * OUT_WIDTH;
  localparam int CW   = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic {EMPTY, BUSY} state_t;
  state_t state, state_n;

  logic [CW-1:0]                 cnt, cnt_n;
  logic [IN_W-1:0]               hold_data;
  logic                          hold_last;
  logic [RATIO-1:0][OUT_WIDTH-1:0] slc;   // slices in emission order
  logic [CW-1:0]                 in_first, nxt_idx;
  logic                          final_slc, s_hs, load_go, busy;

`ifdef AXIS_DOWN_TKEEP_EN
  localparam int KW = OUT_WIDTH / 8;
  logic [RATIO*KW-1:0]       hold_keep;
  logic [RATIO-1:0][KW-1:0]  kslc;
  logic [RATIO-1:0]          nz, in_nz;
  logic                      has_more;
`endif

  // Reorder once, so that the rest of the logic only deals with emission order.
  for (genvar g = 0; g < RATIO; g++) begin : g_slice
    localparam int SRC = (MSB_FIRST != 0) ? (RATIO - 1 - g) : g;
    assign slc[g] = hold_data[SRC*OUT_WIDTH +: OUT_WIDTH];
`ifdef AXIS_DOWN_TKEEP_EN
    assign kslc[g]  = hold_keep[SRC*KW +: KW];
    assign nz[g]    = |hold_keep[SRC*KW +: KW];
    assign in_nz[g] = |s_axis.tkeep[SRC*KW +: KW];
`endif
  end

  assign busy = (state == BUSY);
  assign s_hs = s_axis.tvalid & s_axis.tready;

`ifdef AXIS_DOWN_TKEEP_EN
  // First non-null slice of the incoming word, and next non-null slice after
  // cnt in the held word. When none follows, the current slice is final.
  always_comb begin
    in_first = '0;
    nxt_idx  = cnt;
    has_more = 1'b0;
    for (int i = RATIO - 1; i >= 0; i--) begin
      if (in_nz[i]) in_first = CW'(i);
      if (nz[i] && (i > int'(cnt))) begin
        nxt_idx  = CW'(i);
        has_more = 1'b1;
      end
    end
  end
  assign final_slc    = ~has_more;
  // An all-null word without tlast produces no beat, so it is never loaded.
  assign load_go      = s_hs & ((|in_nz) | s_axis.tlast);
  assign m_axis.tkeep = kslc[cnt];
`else
  assign in_first  = '0;
  assign nxt_idx   = cnt + CW'(1);
  assign final_slc = (cnt == CW'(RATIO - 1));
  assign load_go   = s_hs;
`endif

  // The ready path from m_axis.tready to s_axis.tready on the final slice is
  // combinational. This lets the next word load on the same edge.
  assign s_axis.tready = ~busy | (final_slc & m_axis.tready);
  assign m_axis.tvalid = busy;
  assign m_axis.tdata  = slc[cnt];
  assign m_axis.tlast  = busy & hold_last & final_slc;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= EMPTY;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (!busy) begin
      if (load_go) begin
        state_n = BUSY;
        cnt_n   = in_first;
      end
    end else if (m_axis.tready) begin
      if (!final_slc) begin
        cnt_n = nxt_idx;
      end else if (load_go) begin
        cnt_n = in_first;
      end else begin
        state_n = EMPTY;
        cnt_n   = '0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hold_data <= '0;
      hold_last <= 1'b0;
`ifdef AXIS_DOWN_TKEEP_EN
      hold_keep <= '0;
`endif
    end else if (load_go) begin
      hold_data <= s_axis.tdata;
      hold_last <= s_axis.tlast;
`ifdef AXIS_DOWN_TKEEP_EN
      hold_keep <= s_axis.tkeep;
`endif
    end
  end
endmodule
